// File: rtl/regfile_write_demux.sv
// Write side of the MiniMIPS 8x32 register file: address decode, write-data demux,
// per-register storage with parallel outputs, plus registered write strobe/ack/count.
module regfile_write_demux #(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic             stall,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] D3,
    output logic [WIDTH-1:0] D4,
    output logic [WIDTH-1:0] D5,
    output logic [WIDTH-1:0] D6,
    output logic [WIDTH-1:0] D7,
    output logic [7:0]       wr_strobe,
    output logic             wr_ack,
    output logic [15:0]      wr_count
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [7:0]            sel;
    logic                  accept;
    logic [7:0][WIDTH-1:0] regs;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        sel        = '0;
        sel[waddr] = 1'b1;
    end

    // A write with we=0 never qualifies, so an X on waddr/wdata cannot leak into state.
    assign accept = we & ~stall & ~(ZERO_EN & (waddr == 3'd0));

    for (genvar k = 0; k < 8; k++) begin : g_reg
        if (k == 0 && ZERO_EN) begin : g_zero
            assign regs[k] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] q;

            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            // NOTE: the register file is small enough to live in flops, so each entry gets the async reset.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q <= '0;
                end else if (accept && sel[k]) begin
                    q <= wdata;
                end
            end

            assign regs[k] = q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_strobe <= '0;
            wr_ack    <= 1'b0;
            wr_count  <= '0;
        end else begin
            wr_strobe <= accept ? sel : 8'h00;
            wr_ack    <= accept;
            if (accept) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    assign D0 = regs[0];
    assign D1 = regs[1];
    assign D2 = regs[2];
    assign D3 = regs[3];
    assign D4 = regs[4];
    assign D5 = regs[5];
    assign D6 = regs[6];
    assign D7 = regs[7];

endmodule

// File: tb/tb_regfile_write_demux.sv
// Randomized self-checking bench for regfile_write_demux against an array-based model.
module tb_regfile_write_demux;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic             we;
    logic             stall;
    logic [2:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
    logic [7:0]       wr_strobe;
    logic             wr_ack;
    logic [15:0]      wr_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: plain arrays and integer arithmetic
    logic [WIDTH-1:0] m_reg [8];
    int               m_count;
    logic [7:0]       m_strobe;
    logic             m_ack;

    regfile_write_demux #(.WIDTH(WIDTH), .ZERO_REG(1)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .stall(stall),
        .waddr(waddr), .wdata(wdata),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7),
        .wr_strobe(wr_strobe), .wr_ack(wr_ack), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] dut_reg(input int k);
        case (k)
            0: return D0;
            1: return D1;
            2: return D2;
            3: return D3;
            4: return D4;
            5: return D5;
            6: return D6;
            default: return D7;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_reg[k] = '0;
        m_count  = 0;
        m_strobe = '0;
        m_ack    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 8; k++) check($sformatf("%s_D%0d", tag, k), 64'(dut_reg(k)), 64'(m_reg[k]));
        check({tag, "_strobe"}, 64'(wr_strobe), 64'(m_strobe));
        check({tag, "_ack"},    64'(wr_ack),    64'(m_ack));
        check({tag, "_count"},  64'(wr_count),  64'(m_count));
    endtask

    // Present one set of inputs, clock once, advance the model, then check 1 ns after the edge.
    task automatic cycle(input logic w, input logic s, input logic [2:0] a,
                         input logic [WIDTH-1:0] d, input string tag);
        bit acc;
        we = w; stall = s; waddr = a; wdata = d;
        @(posedge clk);
        if (reset_n) begin
            acc = w && !s && (a != 3'd0);
            if (acc) begin
                m_reg[a] = d;
                m_count  = (m_count + 1) % 65536;
                m_strobe = 8'(1 << a);
            end else begin
                m_strobe = '0;
            end
            m_ack = acc;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int base;
        reset_n = 1'b0;
        we = 1'b0; stall = 1'b0; waddr = '0; wdata = '0;
        model_reset();

        // 1: reset held for three cycles, then idle with junk on address/data
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'(i + 1), $urandom, "rst_hold");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, "idle");

        // 2: sequential fill of registers 1..7
        for (int k = 1; k < 8; k++) begin
            cycle(1'b1, 1'b0, 3'(k), 32'h11111111 * k, "fill");
            check("fill_walk", 64'(wr_strobe), 64'(8'h01 << k));
        end
        check("fill_count", 64'(wr_count), 64'd7);

        // 3: write to register 0 is discarded
        cycle(1'b1, 1'b0, 3'd0, 32'hDEADBEEF, "zero");
        check("zero_D0", 64'(D0), 64'd0);
        check("zero_ack", 64'(wr_ack), 64'd0);
        check("zero_count", 64'(wr_count), 64'd7);

        // 4: stalled write blocked, following write lands
        cycle(1'b1, 1'b1, 3'd3, 32'hCAFEF00D, "stall_blk");
        check("stall_D3_old", 64'(D3), 64'h33333333);
        cycle(1'b1, 1'b0, 3'd3, 32'h12345678, "stall_go");
        check("stall_D3_new", 64'(D3), 64'h12345678);
        check("stall_count", 64'(wr_count), 64'd8);

        // 5: asynchronous reset between edges
        cycle(1'b1, 1'b0, 3'd5, 32'hA5A5A5A5, "pre_arst");
        check("pre_arst_D5", 64'(D5), 64'hA5A5A5A5);
        we = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("arst_D5", 64'(D5), 64'd0);
        check("arst_count", 64'(wr_count), 64'd0);
        check("arst_ack", 64'(wr_ack), 64'd0);
        model_reset();
        check_all("arst");
        #2 reset_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)), $urandom, "rand");
        end
        // Back-to-back to the same register: last write wins
        cycle(1'b1, 1'b0, 3'd4, 32'h0BADF00D, "b2b_a");
        cycle(1'b1, 1'b0, 3'd4, 32'h600DCAFE, "b2b_b");
        check("b2b_D4", 64'(D4), 64'h600DCAFE);

        // 6: preload the counter to 0xFFFF, then wrap with two writes to register 6
        base = m_count;
        for (int i = 0; i < (65535 - base); i++) begin
            cycle(1'b1, 1'b0, 3'($urandom_range(1, 7)), $urandom, "preload");
        end
        check("wrap_pre", 64'(wr_count), 64'hFFFF);
        cycle(1'b1, 1'b0, 3'd6, 32'h1, "wrap_a");
        check("wrap_0", 64'(wr_count), 64'h0000);
        cycle(1'b1, 1'b0, 3'd6, 32'h2, "wrap_b");
        check("wrap_1", 64'(wr_count), 64'h0001);
        check("wrap_D6", 64'(D6), 64'h2);

        cycle(1'b0, 1'b0, 3'd0, '0, "tail");
        check("tail_ack", 64'(wr_ack), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
